// File: rtl/freq_lock_ctrl.sv
// -----------------------------------------------------------------------------
// freq_lock_ctrl
//
// Closed-loop frequency controller for a phase-accumulator oscillator. It
// counts transitions (rising and falling) of signal_in over a gate window of
// max(gate_len,1) clk cycles, compares the count with target_count and, once
// per window, applies a scaled and clamped correction to the tuning word
// speed_var that drives the oscillator.
//
// Window period is max(gate_len,1) MEASURE cycles plus one UPDATE cycle.
//
// Ports
//   clk          : single clock, all logic on posedge
//   rst          : synchronous, active-low reset
//   enable       : run the loop; low returns the FSM to IDLE
//   signal_in    : oscillator toggle output, synchronous to clk
//   gate_len     : window length in clk cycles (0 behaves as 1)
//   target_count : desired transitions per window
//   init_word    : tuning word loaded continuously while IDLE
//   gain_shift   : left shift applied to the error (0..31)
//   speed_var    : tuning word to the oscillator
//   meas_count   : transition count of the last completed window
//   meas_valid   : one-cycle pulse when speed_var / meas_count update
//   locked       : frequency-lock indicator
//
// Build option
//   FREQ_LOCK_DETECT_EN : when defined, the lock counter and locked flag are
//                         built; otherwise locked is tied low and lock_tol /
//                         lock_windows have no effect.
// -----------------------------------------------------------------------------
module freq_lock_ctrl #(
  parameter int bit_count    = 24,
  parameter int gate_bits    = 16,
  parameter int lock_tol     = 1,
  parameter int lock_windows = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 signal_in,
  input  logic [gate_bits-1:0] gate_len,
  input  logic [gate_bits-1:0] target_count,
  input  logic [bit_count-1:0] init_word,
  input  logic [4:0]           gain_shift,
  output logic [bit_count-1:0] speed_var,
  output logic [gate_bits-1:0] meas_count,
  output logic                 meas_valid,
  output logic                 locked
);

  // Wide enough that err <<< 31 added to any tuning word can never overflow.
  localparam int DW = gate_bits + bit_count + 33;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_UPDATE  = 2'd2;

  localparam logic [gate_bits-1:0]  CNT_MAX  = '1;
  localparam logic signed [DW-1:0]  WORD_MIN = DW'(1);
  localparam logic signed [DW-1:0]  WORD_MAX = {{(DW-bit_count){1'b0}}, {bit_count{1'b1}}};

  logic [1:0]           state_q, state_d;
  logic [gate_bits-1:0] gate_cnt_q, gate_cnt_d;
  logic [gate_bits-1:0] edge_cnt_q, edge_cnt_d;
  logic [bit_count-1:0] speed_q, speed_d;
  logic [gate_bits-1:0] meas_q, meas_d;
  logic                 valid_q, valid_d;
  logic                 prev_q;

  logic                 edge_det;
  logic [gate_bits-1:0] gate_last;
  logic signed [gate_bits:0] err;
  logic signed [DW-1:0] err_ext, delta, speed_ext, sum;
  logic [bit_count-1:0] speed_upd;

  assign edge_det  = signal_in ^ prev_q;
  assign gate_last = (gate_len == '0) ? '0 : gate_len - gate_bits'(1);

  // Signed error with one extra bit so target - count never wraps.
  assign err       = $signed({1'b0, target_count}) - $signed({1'b0, edge_cnt_q});
  assign err_ext   = {{(DW-gate_bits-1){err[gate_bits]}}, err};
  assign delta     = err_ext <<< gain_shift;
  assign speed_ext = {{(DW-bit_count){1'b0}}, speed_q};
  assign sum       = speed_ext + delta;

  // Zero is excluded from the clamp range: a stopped oscillator would never
  // produce edges to measure.
  always_comb begin
    if (sum < WORD_MIN) begin
      speed_upd = bit_count'(1);
    end else if (sum > WORD_MAX) begin
      speed_upd = '1;
    end else begin
      speed_upd = sum[bit_count-1:0];
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement leaves it unassigned (which would infer a latch).
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    speed_d    = speed_q;
    meas_d     = meas_q;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        speed_d    = init_word;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        if (enable) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + gate_bits'(1);
          if (edge_det && (edge_cnt_q != CNT_MAX)) edge_cnt_d = edge_cnt_q + gate_bits'(1);
          if (gate_cnt_q == gate_last) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // Edges in this cycle are deliberately not counted.
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          speed_d    = speed_upd;
          meas_d     = edge_cnt_q;
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          state_d    = S_MEASURE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      state_q    <= S_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      speed_q    <= '0;
      meas_q     <= '0;
      valid_q    <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      speed_q    <= speed_d;
      meas_q     <= meas_d;
      valid_q    <= valid_d;
      prev_q     <= signal_in;
    end
  end

  assign speed_var  = speed_q;
  assign meas_count = meas_q;
  assign meas_valid = valid_q;

`ifdef FREQ_LOCK_DETECT_EN
  localparam int                    LW     = $clog2(lock_windows + 1);
  localparam logic [LW-1:0]         LOCK_N = LW'(lock_windows);
  localparam logic signed [gate_bits:0] TOL = (gate_bits+1)'(lock_tol);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic          err_in_tol;

  assign err_in_tol = (err <= TOL) && (err >= -TOL);

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (state_q == S_IDLE) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if ((state_q == S_UPDATE) && enable) begin
      if (err_in_tol) begin
        if (lock_cnt_q != LOCK_N) lock_cnt_d = lock_cnt_q + LW'(1);
        if (lock_cnt_d == LOCK_N) locked_d = 1'b1;
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  localparam int unused_lock_cfg = lock_tol + lock_windows;
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_freq_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_lock_ctrl
//
// Directed bench for freq_lock_ctrl. Stimulus runs in lockstep with the gate
// windows and pushes the hand-computed result of each completed window into a
// scoreboard queue; a monitor pops and compares whenever meas_valid is seen.
// The expected pulse cycle is part of each entry, so window timing is checked
// as well as values.
// -----------------------------------------------------------------------------
module tb_freq_lock_ctrl;

  localparam int BC = 24;
  localparam int GB = 16;

`ifdef FREQ_LOCK_DETECT_EN
  localparam bit LK_EN = 1'b1;
`else
  localparam bit LK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          signal_in = 1'b0;
  logic [GB-1:0] gate_len = 16'd100;
  logic [GB-1:0] target_count = 16'd20;
  logic [BC-1:0] init_word = 24'h100000;
  logic [4:0]    gain_shift = 5'd4;
  logic [BC-1:0] speed_var;
  logic [GB-1:0] meas_count;
  logic          meas_valid;
  logic          locked;

  always #5 clk = ~clk;

  freq_lock_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .signal_in    (signal_in),
    .gate_len     (gate_len),
    .target_count (target_count),
    .init_word    (init_word),
    .gain_shift   (gain_shift),
    .speed_var    (speed_var),
    .meas_count   (meas_count),
    .meas_valid   (meas_valid),
    .locked       (locked)
  );

  typedef struct {
    logic [BC-1:0] speed;
    logic [GB-1:0] meas;
    logic          lk;
    longint        cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every meas_valid must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("meas_count", 64'(meas_count), 64'(mon_e.meas));
        check("speed_var", 64'(speed_var), 64'(mon_e.speed));
        check("locked", 64'(locked), 64'(mon_e.lk));
        check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // One full window: MEASURE cycles with n_edges toggles spread evenly, then
  // a quiet UPDATE cycle. Entered just after the edge that starts MEASURE.
  task automatic window(input int n_edges, input logic [BC-1:0] exp_speed, input logic exp_lock);
    int   n;
    exp_t e;
    n = (gate_len == '0) ? 1 : int'(gate_len);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (((i + 1) * n_edges) / n > (i * n_edges) / n) signal_in = ~signal_in;
    end
    @(negedge clk);
    e.speed = exp_speed;
    e.meas  = GB'(n_edges);
    e.lk    = exp_lock & LK_EN;
    e.cyc   = cyc + 1;
    sb.push_back(e);
  endtask

  // Return to IDLE, load new settings, confirm the IDLE reload, then re-enable.
  task automatic restart(input logic [BC-1:0] iw, input logic [GB-1:0] gl, input logic [4:0] gs);
    @(negedge clk);
    enable     = 1'b0;
    init_word  = iw;
    gate_len   = gl;
    gain_shift = gs;
    @(negedge clk);
    @(negedge clk);
    check("idle_load", 64'(speed_var), 64'(iw));
    enable = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_speed_var", 64'(speed_var), 64'h0);
    check("rst_meas_count", 64'(meas_count), 64'h0);
    check("rst_meas_valid", 64'(meas_valid), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);

    rst = 1'b1;
    @(negedge clk);
    check("init_after_reset", 64'(speed_var), 64'h100000);
    enable = 1'b1;

    // Zero error: lock after 4th window, counter saturates on the 5th.
    for (int k = 0; k < 5; k++) window(20, 24'h100000, k >= 3);

    // Tolerance edges, lock loss, relock.
    window(21, 24'h0FFFF0, 1'b1);
    window(19, 24'h100000, 1'b1);
    window(25, 24'h0FFFB0, 1'b0);
    for (int k = 0; k < 4; k++) window(20, 24'h0FFFB0, k == 3);

    // Reset for one cycle mid-window.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i % 10 == 9) signal_in = ~signal_in;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_speed_var", 64'(speed_var), 64'h0);
    check("midrst_meas_count", 64'(meas_count), 64'h0);
    check("midrst_meas_valid", 64'(meas_valid), 64'h0);
    check("midrst_locked", 64'(locked), 64'h0);
    rst = 1'b1;
    window(25, 24'h0FFFB0, 1'b0);
    window(25, 24'h0FFF60, 1'b0);

    // Abort at cycle 50 of a window: no pulse, IDLE reloads init_word.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 4 == 3) signal_in = ~signal_in;
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_speed_reload", 64'(speed_var), 64'h100000);
    check("abort_locked", 64'(locked), 64'h0);
    repeat (110) @(negedge clk);

    // Clamps, including full-precision shifts at gain 31.
    restart(24'h000010, 16'd100, 5'd4);
    window(25, 24'h000001, 1'b0);
    restart(24'hFFFFF0, 16'd100, 5'd4);
    window(0, 24'hFFFFFF, 1'b0);
    window(0, 24'hFFFFFF, 1'b0);
    restart(24'hFFFFFF, 16'd100, 5'd31);
    window(25, 24'h000001, 1'b0);
    window(0, 24'hFFFFFF, 1'b0);
    restart(24'h100000, 16'd100, 5'd0);
    window(25, 24'h0FFFFB, 1'b0);

    // gate_len = 0 behaves as 1: a pulse every 2 cycles.
    restart(24'h100000, 16'd0, 5'd4);
    window(1, 24'h100130, 1'b0);
    window(0, 24'h100270, 1'b0);
    window(1, 24'h1003A0, 1'b0);

    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
